// File: rtl/alu_op_encoder.sv
// alu_op_encoder: MIPS instruction to 4-bit ALUctrl encoder
// with a 2-entry in-order output queue towards execute.
module alu_op_encoder #(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_aluctrl,
  output logic             out_src_imm,
  output logic             out_imm_zext,
  output logic             out_shamt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [3:0]       aluctrl;
    logic             src_imm;
    logic             imm_zext;
    logic             shamt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } ent_t;

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic       w_unused;
  ent_t       w_enc;
  logic       w_push;
  logic       w_pop;

  ent_t       r_mem [2];
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_count;

  assign w_op     = in_instr[31:26];
  assign w_funct  = in_instr[5:0];
  assign w_unused = ^in_instr[25:6];

  // Combinational decode of op/funct into the ALUctrl entry.
  always_comb begin
    w_enc          = '0;
    w_enc.tag      = in_tag;
    w_enc.illegal  = 1'b1;
    case (w_op)
      6'b000000: begin
        w_enc.illegal = 1'b0;
        case (w_funct)
          6'b100000,
          6'b100001: w_enc.aluctrl = 4'b0000;
          6'b100010,
          6'b100011: w_enc.aluctrl = 4'b1000;
          6'b000000: begin
            w_enc.aluctrl = 4'b0001;
            w_enc.shamt   = 1'b1;
          end
          6'b000010: begin
            w_enc.aluctrl = 4'b0101;
            w_enc.shamt   = 1'b1;
          end
          6'b000011: begin
            w_enc.aluctrl = 4'b1101;
            w_enc.shamt   = 1'b1;
          end
          6'b000100: w_enc.aluctrl = 4'b0001;
          6'b000110: w_enc.aluctrl = 4'b0101;
          6'b000111: w_enc.aluctrl = 4'b1101;
          6'b101011: w_enc.aluctrl = 4'b0010;
          6'b101010: w_enc.aluctrl = 4'b1010;
          6'b100100: w_enc.aluctrl = 4'b0011;
          6'b100101: w_enc.aluctrl = 4'b0100;
          6'b100110: w_enc.aluctrl = 4'b0110;
          6'b100111: w_enc.aluctrl = 4'b0111;
          default:   w_enc.illegal = 1'b1;
        endcase
      end
      6'b001000,
      6'b001001,
      6'b100011,
      6'b101011: begin
        w_enc.illegal = 1'b0;
        w_enc.aluctrl = 4'b0000;
        w_enc.src_imm = 1'b1;
      end
      6'b000100,
      6'b000101: begin
        w_enc.illegal = 1'b0;
        w_enc.aluctrl = 4'b1000;
      end
      6'b001010: begin
        w_enc.illegal = 1'b0;
        w_enc.aluctrl = 4'b1010;
        w_enc.src_imm = 1'b1;
      end
      6'b001011: begin
        w_enc.illegal = 1'b0;
        w_enc.aluctrl = 4'b0010;
        w_enc.src_imm = 1'b1;
      end
      6'b001100: begin
        w_enc.illegal  = 1'b0;
        w_enc.aluctrl  = 4'b0011;
        w_enc.src_imm  = 1'b1;
        w_enc.imm_zext = 1'b1;
      end
      6'b001101: begin
        w_enc.illegal  = 1'b0;
        w_enc.aluctrl  = 4'b0100;
        w_enc.src_imm  = 1'b1;
        w_enc.imm_zext = 1'b1;
      end
      6'b001110: begin
        w_enc.illegal  = 1'b0;
        w_enc.aluctrl  = 4'b0110;
        w_enc.src_imm  = 1'b1;
        w_enc.imm_zext = 1'b1;
      end
      6'b001111: begin
        w_enc.illegal  = 1'b0;
        w_enc.aluctrl  = 4'b1111;
        w_enc.src_imm  = 1'b1;
        w_enc.imm_zext = 1'b1;
      end
      default: w_enc.illegal = 1'b1;
    endcase
    if (w_enc.illegal) begin
      w_enc.aluctrl  = 4'b0000;
      w_enc.src_imm  = 1'b0;
      w_enc.imm_zext = 1'b0;
      w_enc.shamt    = 1'b0;
    end
  end

  assign in_ready  = (r_count < 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  // Queue storage; written on a push edge only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr] <= w_enc;
    end
  end

  // Pointers and occupancy; flush clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else if (flush) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_aluctrl  = r_mem[r_rptr].aluctrl;
  assign out_src_imm  = r_mem[r_rptr].src_imm;
  assign out_imm_zext = r_mem[r_rptr].imm_zext;
  assign out_shamt    = r_mem[r_rptr].shamt;
  assign out_illegal  = r_mem[r_rptr].illegal;
  assign out_tag      = r_mem[r_rptr].tag;

endmodule

// File: tb/tb_alu_op_encoder.sv
// tb_alu_op_encoder: directed vectors for alu_op_encoder
// with hand-computed expected encodings.
module tb_alu_op_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_aluctrl;
  logic        out_src_imm;
  logic        out_imm_zext;
  logic        out_shamt;
  logic        out_illegal;
  logic [7:0]  out_tag;

  int n_checks = 0;
  int n_errors = 0;

  alu_op_encoder #(.TAG_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_aluctrl  (out_aluctrl),
    .out_src_imm  (out_src_imm),
    .out_imm_zext (out_imm_zext),
    .out_shamt    (out_shamt),
    .out_illegal  (out_illegal),
    .out_tag      (out_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [5:0] f);
    return {6'b000000, 20'h12345, f};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op);
    return {op, 26'h0ABCDEF};
  endfunction

  task automatic check(input string name,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic chk_head(input string name, input logic [3:0] ctrl,
                          input logic imm, input logic zx,
                          input logic sh, input logic ill,
                          input logic [7:0] tag);
    check({name, ".valid"}, 32'(out_valid), 32'd1);
    check({name, ".ctrl"}, 32'(out_aluctrl), 32'(ctrl));
    check({name, ".imm"}, 32'(out_src_imm), 32'(imm));
    check({name, ".zext"}, 32'(out_imm_zext), 32'(zx));
    check({name, ".shamt"}, 32'(out_shamt), 32'(sh));
    check({name, ".ill"}, 32'(out_illegal), 32'(ill));
    check({name, ".tag"}, 32'(out_tag), 32'(tag));
  endtask

  task automatic chk_zero(input string name);
    check({name, ".valid"}, 32'(out_valid), 32'd0);
    check({name, ".ready"}, 32'(in_ready), 32'd1);
    check({name, ".ctrl"}, 32'(out_aluctrl), 32'd0);
    check({name, ".imm"}, 32'(out_src_imm), 32'd0);
    check({name, ".zext"}, 32'(out_imm_zext), 32'd0);
    check({name, ".shamt"}, 32'(out_shamt), 32'd0);
    check({name, ".ill"}, 32'(out_illegal), 32'd0);
    check({name, ".tag"}, 32'(out_tag), 32'd0);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  tag;
    logic [3:0]  ctrl;
    logic        imm;
    logic        zx;
    logic        sh;
  } vec_t;

  vec_t seq [4];

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    #1;
    chk_zero("rst");
    step();
    step();
    rst_n = 1'b1;
    step();
    chk_zero("post_rst");

    // Single SUB
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = rtype(6'b100010);
    in_tag    = 8'h11;
    step();
    chk_head("sub", 4'b1000, 0, 0, 0, 0, 8'h11);
    in_valid = 1'b0;
    step();
    check("sub.drain", 32'(out_valid), 32'd0);

    // Back-to-back stream
    seq[0] = '{rtype(6'b000000), 8'h30, 4'b0001, 0, 0, 1};
    seq[1] = '{rtype(6'b000111), 8'h31, 4'b1101, 0, 0, 0};
    seq[2] = '{itype(6'b001010), 8'h32, 4'b1010, 1, 0, 0};
    seq[3] = '{itype(6'b001101), 8'h33, 4'b0100, 1, 1, 0};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_instr = seq[i].instr;
      in_tag   = seq[i].tag;
      step();
      chk_head($sformatf("b2b%0d", i), seq[i].ctrl, seq[i].imm,
               seq[i].zx, seq[i].sh, 1'b0, seq[i].tag);
      check($sformatf("b2b%0d.rdy", i), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    step();
    check("b2b.drain", 32'(out_valid), 32'd0);

    // Stall: ADDIU, LUI fill the queue; AND held off
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = itype(6'b001001);
    in_tag    = 8'h40;
    step();
    chk_head("addiu", 4'b0000, 1, 0, 0, 0, 8'h40);
    check("addiu.rdy", 32'(in_ready), 32'd1);
    in_instr = itype(6'b001111);
    in_tag   = 8'h41;
    step();
    check("full.rdy", 32'(in_ready), 32'd0);
    chk_head("stall1", 4'b0000, 1, 0, 0, 0, 8'h40);
    in_instr = rtype(6'b100100);
    in_tag   = 8'h42;
    step();
    check("held.rdy", 32'(in_ready), 32'd0);
    chk_head("stall2", 4'b0000, 1, 0, 0, 0, 8'h40);
    out_ready = 1'b1;
    step();
    chk_head("lui", 4'b1111, 1, 1, 0, 0, 8'h41);
    step();
    in_valid = 1'b0;
    chk_head("and", 4'b0011, 0, 0, 0, 0, 8'h42);
    step();
    check("stall.drain", 32'(out_valid), 32'd0);

    // Illegal op in the middle of a stream
    in_valid = 1'b1;
    in_instr = rtype(6'b100000);
    in_tag   = 8'h21;
    step();
    chk_head("ill.pre", 4'b0000, 0, 0, 0, 0, 8'h21);
    in_instr = {6'h3F, 26'h3FFFFFF};
    in_tag   = 8'h22;
    step();
    chk_head("ill", 4'b0000, 0, 0, 0, 1, 8'h22);
    in_instr = rtype(6'b100101);
    in_tag   = 8'h23;
    step();
    chk_head("ill.post", 4'b0100, 0, 0, 0, 0, 8'h23);
    in_instr = rtype(6'b111111);
    in_tag   = 8'h24;
    step();
    chk_head("ill.funct", 4'b0000, 0, 0, 0, 1, 8'h24);
    in_valid = 1'b0;
    step();

    // Flush with a full queue and a simultaneous push
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = rtype(6'b100110);
    in_tag    = 8'h50;
    step();
    in_instr = rtype(6'b100111);
    in_tag   = 8'h51;
    step();
    check("fl.full", 32'(in_ready), 32'd0);
    flush    = 1'b1;
    in_instr = itype(6'b001000);
    in_tag   = 8'h52;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl.valid", 32'(out_valid), 32'd0);
    check("fl.rdy", 32'(in_ready), 32'd1);
    step();
    check("fl.noq", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-cycle with one entry queued
    in_valid = 1'b1;
    in_instr = rtype(6'b101011);
    in_tag   = 8'h60;
    step();
    in_valid = 1'b0;
    chk_head("sltu", 4'b0010, 0, 0, 0, 0, 8'h60);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("arst");
    step();
    rst_n = 1'b1;
    step();
    chk_zero("arst.rel");

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
